hazard_stall_unit: RTL and testbench
====================================

Name: hazard_stall_unit

Overview:
Pipeline hazard detector that sits directly upstream of the ID-stage control-zeroing mux. It drives that mux's select to insert a bubble, and it freezes the PC and the IF/ID register.
- Detects load-use hazards.
- Tracks the multi-cycle multiply/divide unit so that HI/LO readers and back-to-back mult/div instructions wait.
- Keeps a saturating stall-cycle counter for performance debug.

Parameters:
MD_LATENCY, 4, cycles the mult/div unit stays busy after the cycle it is started (1..15)
CNT_W, 16, width of the stall performance counter

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  synchronous active-low reset
id_rs  in  5  rs field of instruction in ID
id_rt  in  5  rt field of instruction in ID
id_uses_rt  in  1  ID instruction reads rt as a source (R-type, beq/bne, sw)
id_hilo_read  in  1  ID instruction is mfhi/mflo
id_md_op  in  1  ID instruction is mult/multu/div/divu
ex_mem_read  in  1  EX-stage instruction is a load
ex_rt  in  5  destination rt of EX-stage instruction
ex_md_start  in  1  one-cycle pulse: mult/div instruction is in EX this cycle
ex_branch_taken  in  1  branch/jump resolved taken in EX
pc_write  out  1  1 = PC may update
ifid_write  out  1  1 = IF/ID register may load
ifid_flush  out  1  1 = IF/ID register loads a NOP
ctrl_sel  out  1  to control-zeroing mux select; 1 = zero all ID control signals (bubble)
md_busy  out  1  mult/div unit busy (registered count nonzero)
stall_count  out  CNT_W  saturating count of stall cycles since reset

Behaviour:
State:
- md_cnt, 4 bits.
- stall_count, CNT_W bits.
- Both are cleared on a clk edge with rst_n=0.
- While rst_n=0, all outputs take their idle values: pc_write=1, ifid_write=1, ifid_flush=0, ctrl_sel=0, md_busy=0, stall_count=0. Inputs are ignored.

Load-use hazard:
- load_use = ex_mem_read & (ex_rt != 0) & ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt))).

Mult/div hazard:
- md_pending = (md_cnt != 0) | ex_md_start.
- md_stall = md_pending & (id_hilo_read | id_md_op).

Stall and outputs (all combinational from inputs and registered state, zero latency):
- stall = load_use | md_stall.
- pc_write = ~stall; ifid_write = ~stall.
- ctrl_sel = stall | ex_branch_taken.
- ifid_flush = ex_branch_taken.
- md_busy = (md_cnt != 0).

Branch priority:
- ex_branch_taken overrides stall for pc_write and ifid_write: both are forced to 1 so the redirect is taken.
- ctrl_sel stays 1.
- In that cycle the stall does not count.

md_cnt update:
- If ex_md_start: load MD_LATENCY. This reloads even if already nonzero.
- Else if nonzero: decrement by 1.
- Else: hold at 0.
- It never wraps below 0.

stall_count:
- Increments by 1 on each edge where stall=1 and ex_branch_taken=0.
- Saturates at all-ones.

Resulting latency and edge cases:
- mfhi in ID in the same cycle as ex_md_start stalls MD_LATENCY+1 cycles, then releases.
- When md_cnt reaches 0, release happens in the same cycle (no extra bubble).
- ex_rt=0 never causes a load-use stall.
- load_use and md_stall in the same cycle count as one stall cycle.
- Reset asserted mid-countdown clears md_cnt at that edge. md_busy=0 from the next cycle.

Test Plan:
1. Load-use: ex_mem_read=1, ex_rt=8, id_rs=8, one cycle -> pc_write=0, ifid_write=0, ctrl_sel=1 that cycle; stall_count 0->1. Repeat with ex_rt=0 -> no stall.
2. rt source: ex_mem_read=1, ex_rt=9, id_rt=9 with id_uses_rt=0 -> no stall; with id_uses_rt=1 -> stall.
3. Mult then mfhi (MD_LATENCY=4): ex_md_start pulse with id_hilo_read held 1 -> stall for exactly 5 cycles, md_busy=1 for the last 4 cycles (md_cnt 4,3,2,1); pc_write returns to 1 on cycle 6; stall_count=5.
4. Branch during stall: md_cnt=2, id_hilo_read=1, ex_branch_taken=1 -> ifid_flush=1, ctrl_sel=1, pc_write=1, stall_count unchanged.
5. Reset mid-op: md_cnt=3, drive rst_n=0 for one edge -> md_cnt=0, md_busy=0, stall_count=0, pc_write=1 next cycle with idle inputs.
6. Saturation (CNT_W=4): hold load_use for 20 cycles -> stall_count stops at 15.

Source files
------------

// File: rtl/hazard_stall_unit.sv
// Hazard/stall unit: load-use and mult/div interlocks feeding the ID-stage
// control-zeroing mux, PC and IF/ID write enables, plus a stall counter.
module hazard_stall_unit #(
  parameter int unsigned MD_LATENCY = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             id_hilo_read,
  input  logic             id_md_op,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             ex_md_start,
  input  logic             ex_branch_taken,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             ctrl_sel,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_count
);

  localparam int unsigned MD_W = 4;

  logic [MD_W-1:0]  md_cnt;
  logic [CNT_W-1:0] stall_cnt;
  logic             load_use;
  logic             md_pending;
  logic             md_stall;
  logic             stall;
  logic             count_en;

  // Hazard detection; a taken branch redirects and masks stall accounting
  always_comb begin
    load_use   = ex_mem_read && (ex_rt != 5'd0) &&
                 ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    md_pending = (md_cnt != '0) || ex_md_start;
    md_stall   = md_pending && (id_hilo_read || id_md_op);
    stall      = load_use || md_stall;
    count_en   = stall && !ex_branch_taken;
  end

  // Zero-latency control outputs, forced idle while reset is held
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    ctrl_sel    = 1'b0;
    md_busy     = 1'b0;
    stall_count = '0;
    if (rst_n) begin
      pc_write    = !stall || ex_branch_taken;
      ifid_write  = !stall || ex_branch_taken;
      ifid_flush  = ex_branch_taken;
      ctrl_sel    = stall || ex_branch_taken;
      md_busy     = (md_cnt != '0);
      stall_count = stall_cnt;
    end
  end

  // Mult/div busy countdown, reloaded on every start pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      md_cnt <= '0;
    end else if (ex_md_start) begin
      md_cnt <= MD_W'(MD_LATENCY);
    end else if (md_cnt != '0) begin
      md_cnt <= md_cnt - MD_W'(1);
    end
  end

  // Saturating stall-cycle counter for performance debug
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (count_en && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit: a 16-bit counter instance and a
// 4-bit counter instance share stimulus; expectations flow through a queue.
module tb_hazard_stall_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       id_uses_rt, id_hilo_read, id_md_op;
  logic       ex_mem_read, ex_md_start, ex_branch_taken;

  logic        pc_write, ifid_write, ifid_flush, ctrl_sel, md_busy;
  logic [15:0] stall_count;
  logic        pc_write4, ifid_write4, ifid_flush4, ctrl_sel4, md_busy4;
  logic [3:0]  stall_count4;

  typedef struct {
    logic        pc_write;
    logic        ifid_write;
    logic        ifid_flush;
    logic        ctrl_sel;
    logic        md_busy;
    logic [15:0] cnt16;
    logic [3:0]  cnt4;
  } exp_t;

  exp_t exp_q[$];

  int asserts = 0;
  int fails   = 0;

  int md_m  = 0;
  int cnt16 = 0;
  int cnt4  = 0;

  always #5 clk = ~clk;

  hazard_stall_unit #(.MD_LATENCY(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .id_hilo_read(id_hilo_read), .id_md_op(id_md_op),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .ex_md_start(ex_md_start),
    .ex_branch_taken(ex_branch_taken), .pc_write(pc_write),
    .ifid_write(ifid_write), .ifid_flush(ifid_flush), .ctrl_sel(ctrl_sel),
    .md_busy(md_busy), .stall_count(stall_count)
  );

  hazard_stall_unit #(.MD_LATENCY(4), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .id_hilo_read(id_hilo_read), .id_md_op(id_md_op),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .ex_md_start(ex_md_start),
    .ex_branch_taken(ex_branch_taken), .pc_write(pc_write4),
    .ifid_write(ifid_write4), .ifid_flush(ifid_flush4), .ctrl_sel(ctrl_sel4),
    .md_busy(md_busy4), .stall_count(stall_count4)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    asserts++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Drive one cycle, push the expected outputs, compare mid-cycle, advance model
  task automatic cycle(input logic rn, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urt, input logic hr, input logic mdop,
                       input logic mr, input logic [4:0] ert, input logic mds,
                       input logic bt, input string tag);
    exp_t e;
    exp_t g;
    bit lu, st;
    rst_n = rn; id_rs = rs; id_rt = rt; id_uses_rt = urt; id_hilo_read = hr;
    id_md_op = mdop; ex_mem_read = mr; ex_rt = ert; ex_md_start = mds;
    ex_branch_taken = bt;
    lu = mr && (ert != 0) && ((ert == rs) || (urt && (ert == rt)));
    st = lu || (((md_m != 0) || mds) && (hr || mdop));
    if (!rn) begin
      e = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 4'd0};
    end else begin
      e.pc_write   = !st || bt;
      e.ifid_write = !st || bt;
      e.ifid_flush = bt;
      e.ctrl_sel   = st || bt;
      e.md_busy    = (md_m != 0);
      e.cnt16      = 16'(cnt16);
      e.cnt4       = 4'(cnt4);
    end
    exp_q.push_back(e);
    @(negedge clk);
    asserts++;
    assert (exp_q.size() > 0) else begin
      fails++;
      $error("FAIL %s_queue: observed empty expected entry", tag);
    end
    if (exp_q.size() > 0) begin
      g = exp_q.pop_front();
      chk({tag, "_pc_write"},   16'(pc_write),   16'(g.pc_write));
      chk({tag, "_ifid_write"}, 16'(ifid_write), 16'(g.ifid_write));
      chk({tag, "_ifid_flush"}, 16'(ifid_flush), 16'(g.ifid_flush));
      chk({tag, "_ctrl_sel"},   16'(ctrl_sel),   16'(g.ctrl_sel));
      chk({tag, "_md_busy"},    16'(md_busy),    16'(g.md_busy));
      chk({tag, "_count16"},    stall_count,     g.cnt16);
      chk({tag, "_count4"},     16'(stall_count4), 16'(g.cnt4));
      chk({tag, "_pc_write4"},  16'(pc_write4),  16'(g.pc_write));
    end
    @(posedge clk);
    if (!rn) begin
      md_m = 0; cnt16 = 0; cnt4 = 0;
    end else begin
      if (mds) md_m = 4;
      else if (md_m > 0) md_m = md_m - 1;
      if (st && !bt) begin
        if (cnt16 < 65535) cnt16++;
        if (cnt4 < 15) cnt4++;
      end
    end
    #1;
  endtask

  task automatic idle(input string tag);
    cycle(1, 5'd1, 5'd2, 0, 0, 0, 0, 5'd0, 0, 0, tag);
  endtask

  initial begin
    @(posedge clk); #1;
    // reset with hazard-looking inputs: must stay idle
    cycle(0, 5'd8, 5'd0, 0, 1, 0, 1, 5'd8, 1, 0, "rst_a");
    cycle(0, 5'd8, 5'd0, 0, 0, 0, 1, 5'd8, 0, 0, "rst_b");
    idle("post_rst");
    // 1. load-use on rs, then ex_rt = 0 never stalls
    cycle(1, 5'd8, 5'd3, 0, 0, 0, 1, 5'd8, 0, 0, "lu_rs");
    idle("lu_after");
    cycle(1, 5'd0, 5'd0, 1, 0, 0, 1, 5'd0, 0, 0, "lu_r0");
    // 2. rt source only when the instruction uses rt
    cycle(1, 5'd4, 5'd9, 0, 0, 0, 1, 5'd9, 0, 0, "rt_unused");
    cycle(1, 5'd4, 5'd9, 1, 0, 0, 1, 5'd9, 0, 0, "rt_used");
    cycle(1, 5'd9, 5'd9, 1, 0, 0, 0, 5'd9, 0, 0, "no_load");
    // 3. mult then mfhi held: 5 stall cycles, release on the 6th
    cycle(1, 5'd0, 5'd0, 0, 1, 0, 0, 5'd0, 1, 0, "md_start");
    for (int i = 0; i < 4; i++) cycle(1, 5'd0, 5'd0, 0, 1, 0, 0, 5'd0, 0, 0, "md_wait");
    cycle(1, 5'd0, 5'd0, 0, 1, 0, 0, 5'd0, 0, 0, "md_release");
    // back-to-back md op waits; combined load-use + md counts once
    cycle(1, 5'd0, 5'd0, 0, 0, 1, 0, 5'd0, 1, 0, "md_b2b");
    cycle(1, 5'd7, 5'd0, 0, 0, 1, 1, 5'd7, 0, 0, "md_and_lu");
    cycle(1, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 1, 0, "md_reload");
    idle("md_cnt3"); idle("md_cnt2"); idle("md_cnt1"); idle("md_cnt0");
    // 4. branch during md stall at md_cnt = 2
    cycle(1, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 1, 0, "br_setup");
    idle("br_cnt4"); idle("br_cnt3");
    cycle(1, 5'd0, 5'd0, 0, 1, 0, 0, 5'd0, 0, 1, "br_taken");
    cycle(1, 5'd0, 5'd0, 0, 1, 0, 0, 5'd0, 0, 0, "br_after");
    idle("br_drain");
    // 5. reset mid-countdown at md_cnt = 3
    cycle(1, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 1, 0, "rm_start");
    idle("rm_cnt4");
    cycle(0, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0, "rm_reset");
    idle("rm_idle");
    cycle(1, 5'd0, 5'd0, 0, 1, 0, 0, 5'd0, 0, 0, "rm_hilo");
    // 6. hold load-use for 20 cycles: 4-bit counter saturates at 15
    for (int i = 0; i < 20; i++) cycle(1, 5'd12, 5'd0, 0, 0, 0, 1, 5'd12, 0, 0, "sat");
    idle("sat_end");
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
